// File: rtl/i2c_write_sequencer_pkg.sv
// Purpose: shared types and constants for the I2C register-write sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE,
    GAP,
    FINISH
  } state_t;

  // Position of each byte within one register write.
  localparam logic [1:0] BYTE_ADDR = 2'd0;
  localparam logic [1:0] BYTE_REG  = 2'd1;
  localparam logic [1:0] BYTE_DATA = 2'd2;

  // R/W bit appended to the 7-bit device address.
  localparam logic I2C_WRITE = 1'b0;

endpackage

// File: rtl/i2c_write_sequencer_cycle_timer.sv
// Purpose: clear/enable cycle counter that flags the LIMIT-th enabled cycle.
// Latency: expire is combinational in the LIMIT-th enabled cycle after a clear.
// Backpressure: none; en simply pauses counting.
// Ports: clk, rst (sync, active-high), clr (zero the count), en (count this
//        cycle), expire (this enabled cycle is the LIMIT-th since the clear).
module cycle_timer #(
  parameter  int LIMIT = 4,
  localparam int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  // The owner changes state on expire and clears us, so cnt never passes LIMIT-1.
  assign expire = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/i2c_write_sequencer.sv
// Purpose: turns one register-write request into addr/reg/data bytes for the I2C byte transmitter.
// Latency: first send_en one cycle after acceptance; done one cycle after the last byte's busy fall.
// Backpressure: req_ready only in IDLE; transmitter paced by tx_busy, stalls bounded by TIMEOUT_CYCLES.
// Ports: clk, rst (sync, active-high); req_valid/req_ready + req_dev_addr/req_reg_addr/req_data
//        (request); tx_data/tx_is_addr/tx_send_en/tx_busy (transmitter); busy, done, error,
//        err_byte (status to host).
module i2c_write_sequencer
  import i2c_pkg::*;
#(
  parameter int BUS_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [6:0]           req_dev_addr,
  input  logic [BUS_WIDTH-1:0] req_reg_addr,
  input  logic [BUS_WIDTH-1:0] req_data,
  output logic [BUS_WIDTH-1:0] tx_data,
  output logic                 tx_is_addr,
  output logic                 tx_send_en,
  input  logic                 tx_busy,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_byte
);

  state_t               state_q, state_d;
  logic [1:0]           byte_idx_q;
  logic [BUS_WIDTH-1:0] reg_q, data_q;
  logic                 accept, in_wait, state_chg, timeout, gap_done;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign in_wait   = (state_q == ISSUE) || (state_q == WAIT_ACCEPT) || (state_q == WAIT_DONE);
  assign state_chg = (state_d != state_q);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);

  // Both timers restart on every state change, so each wait is bounded on its own.
  cycle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_chg),
    .en     (in_wait),
    .expire (timeout)
  );

  cycle_timer #(.LIMIT(GAP_CYCLES)) u_gap (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_chg),
    .en     (state_q == GAP),
    .expire (gap_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_send_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        // Timeout wins so an aborted byte never gets a late send_en.
        if (timeout) begin
          state_d = IDLE;
        end else if (!tx_busy) begin
          tx_send_en = 1'b1;
          state_d    = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        if (timeout)      state_d = IDLE;
        else if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (timeout)       state_d = IDLE;
        else if (!tx_busy) state_d = (byte_idx_q == BYTE_DATA) ? FINISH : GAP;
      end
      GAP: begin
        if (gap_done) state_d = ISSUE;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // tx_data/tx_is_addr load only on the edge entering ISSUE (accept or gap end),
  // so they stay put for the whole byte the transmitter is shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= BYTE_ADDR;
      reg_q      <= '0;
      data_q     <= '0;
      tx_data    <= '0;
      tx_is_addr <= 1'b0;
      error      <= 1'b0;
      err_byte   <= 2'd0;
    end else begin
      error <= timeout;
      if (timeout) err_byte <= byte_idx_q;
      if (accept) begin
        byte_idx_q <= BYTE_ADDR;
        reg_q      <= req_reg_addr;
        data_q     <= req_data;
        tx_data    <= BUS_WIDTH'({req_dev_addr, I2C_WRITE});
        tx_is_addr <= 1'b1;
      end else if (gap_done) begin
        byte_idx_q <= byte_idx_q + 2'd1;
        tx_data    <= ((byte_idx_q + 2'd1) == BYTE_REG) ? reg_q : data_q;
        tx_is_addr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Purpose: self-checking bench for i2c_write_sequencer against a cycle-level transmitter model.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_write_sequencer;

  localparam int TO  = 100;
  localparam int GAP = 3;

  logic       clk, rst, req_valid, req_ready;
  logic [6:0] req_dev_addr;
  logic [7:0] req_reg_addr, req_data, tx_data;
  logic       tx_is_addr, tx_send_en, tx_busy, busy, done, error;
  logic [1:0] err_byte;

  i2c_write_sequencer #(
    .BUS_WIDTH      (8),
    .TIMEOUT_CYCLES (TO),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dev_addr (req_dev_addr),
    .req_reg_addr (req_reg_addr),
    .req_data     (req_data),
    .tx_data      (tx_data),
    .tx_is_addr   (tx_is_addr),
    .tx_send_en   (tx_send_en),
    .tx_busy      (tx_busy),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_byte     (err_byte)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int vec, mis, cyc;

  // Reference model: a request becomes three expected bytes; timing is
  // predicted from the transmitter's busy falls (GAP+1 cycles to next send,
  // one cycle to done, ready again the cycle after done).
  bit         chk_on, m_ready;
  int         exp_send_cyc, exp_done_cyc, fall_idx, n_acc, acc_cyc;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  // Transmitter model state.
  int acc_cnt, bsy_cnt, bsy_len, bsy_fixed, sends, stuck_byte, never_byte;
  bit xm_stuck;
  int n_done, n_err, err_cyc, last_done_cyc;

  typedef struct {
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] dt;
    logic [8:0] e0, e1, e2;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    vec++;
    mis++;
    $display("FAIL %s @cyc %0d: bound expired", nm, cyc);
  endtask

  task automatic xm_clear();
    tx_busy    = 1'b0;
    acc_cnt    = 0;
    bsy_cnt    = 0;
    xm_stuck   = 1'b0;
    stuck_byte = -1;
    never_byte = -1;
    sends      = 0;
  endtask

  // One clock: model acceptance before the edge, transmitter update at the
  // falling edge, DUT observation 2 units later.
  task automatic step();
    if (chk_on && req_valid && m_ready) begin
      exp_q.push_back({1'b1, req_dev_addr, 1'b0});
      exp_q.push_back({1'b0, req_reg_addr});
      exp_q.push_back({1'b0, req_data});
      exp_send_cyc = cyc + 1;
      acc_cyc      = cyc;
      m_ready      = 1'b0;
      fall_idx     = 0;
      n_acc++;
    end
    @(posedge clk);
    cyc++;
    if (chk_on && cyc == exp_done_cyc + 1) m_ready = 1'b1;
    @(negedge clk);
    if (acc_cnt > 0) begin
      acc_cnt--;
      if (acc_cnt == 0) begin
        tx_busy = 1'b1;
        bsy_cnt = bsy_len;
      end
    end else if (tx_busy && !xm_stuck) begin
      bsy_cnt--;
      if (bsy_cnt == 0) begin
        tx_busy = 1'b0;
        if (chk_on) begin
          if (fall_idx == 2) exp_done_cyc = cyc + 1;
          else exp_send_cyc = cyc + GAP + 1;
          fall_idx++;
        end
      end
    end
    #2;
    chk("send_while_busy", tx_send_en & tx_busy, 0);
    chk("done_and_error", done & error, 0);
    if (done) begin
      n_done++;
      last_done_cyc = cyc;
    end
    if (error) begin
      n_err++;
      err_cyc = cyc;
    end
    if (chk_on) begin
      chk("send_en", tx_send_en, cyc == exp_send_cyc);
      chk("done", done, cyc == exp_done_cyc);
      chk("error", error, 0);
      chk("req_ready", req_ready, m_ready);
      chk("busy", busy, !m_ready);
      if (tx_send_en) begin
        if (exp_q.size() == 0) fail("unexpected_byte");
        else chk("byte", {tx_is_addr, tx_data}, exp_q.pop_front());
      end
    end
    if (tx_send_en) begin
      got_q.push_back({tx_is_addr, tx_data});
      if (sends == stuck_byte) xm_stuck = 1'b1;
      if (sends != never_byte) begin
        acc_cnt = $urandom_range(1, 3);
        bsy_len = (bsy_fixed > 0) ? bsy_fixed : $urandom_range(1, 6);
      end
      sends++;
    end
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 500 && !m_ready; i++) step();
    if (!m_ready) fail(nm);
  endtask

  task automatic set_req(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v);
    req_dev_addr = d;
    req_reg_addr = r;
    req_data     = v;
  endtask

  task automatic chk_got(input string nm, input int base,
                         input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2);
    if (got_q.size() < base + 3) begin
      chk({nm, "_count"}, got_q.size(), base + 3);
    end else begin
      chk({nm, "_b0"}, got_q[base],     e0);
      chk({nm, "_b1"}, got_q[base + 1], e1);
      chk({nm, "_b2"}, got_q[base + 2], e2);
    end
  endtask

  initial begin
    int d0, a0, c1, r1;
    vec = 0; mis = 0; cyc = 0;
    chk_on = 1'b0; m_ready = 1'b0;
    exp_send_cyc = -10; exp_done_cyc = -10; fall_idx = 0; n_acc = 0; acc_cyc = -10;
    n_done = 0; n_err = 0; err_cyc = -1; last_done_cyc = -10;
    bsy_fixed = 0; bsy_len = 1;
    xm_clear();
    rst = 1'b1; req_valid = 1'b0;
    set_req(7'h00, 8'h00, 8'h00);

    tbl[0] = '{7'h68, 8'h6B, 8'h00, 9'h1D0, 9'h06B, 9'h000};
    tbl[1] = '{7'h7F, 8'hFF, 8'hA5, 9'h1FE, 9'h0FF, 9'h0A5};
    tbl[2] = '{7'h00, 8'h01, 8'h80, 9'h100, 9'h001, 9'h080};
    tbl[3] = '{7'h2A, 8'h55, 8'hC3, 9'h154, 9'h055, 9'h0C3};

    // Reset values, including req_ready held low while rst is high.
    step(); step();
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_is_addr", tx_is_addr, 0);
    chk("rst_tx_send_en", tx_send_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_byte", err_byte, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    step();
    chk("rst_release_ready", req_ready, 1);
    chk_on = 1'b1; m_ready = 1'b1;

    // Table-driven single writes.
    foreach (tbl[k]) begin
      got_q.delete();
      d0 = n_done;
      set_req(tbl[k].dev, tbl[k].rg, tbl[k].dt);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      wait_idle("tbl_idle");
      chk_got("tbl", 0, tbl[k].e0, tbl[k].e1, tbl[k].e2);
      chk("tbl_done_count", n_done - d0, 1);
      chk("tbl_busy_after", busy, 0);
    end

    // Back-to-back with req_valid held: second accepted the cycle after done.
    got_q.delete();
    a0 = n_acc;
    set_req(7'h68, 8'h1B, 8'h18);
    req_valid = 1'b1;
    step();
    set_req(7'h68, 8'h1C, 8'h10);
    for (int i = 0; i < 500 && n_acc < a0 + 2; i++) step();
    req_valid = 1'b0;
    if (n_acc < a0 + 2) fail("b2b_second_accept");
    chk("b2b_accept_after_done", acc_cyc, last_done_cyc + 1);
    wait_idle("b2b_idle");
    chk_got("b2b_first", 0, 9'h1D0, 9'h01B, 9'h018);
    chk_got("b2b_second", 3, 9'h1D0, 9'h01C, 9'h010);

    // Request fields and valid wiggled mid-transaction: only the captured request is sent.
    got_q.delete();
    set_req(7'h3C, 8'h20, 8'h7E);
    req_valid = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      set_req(7'($urandom), 8'($urandom), 8'($urandom));
      step();
    end
    req_valid = 1'b0;
    wait_idle("mid_idle");
    chk("mid_count", got_q.size(), 3);
    chk_got("mid", 0, 9'h178, 9'h020, 9'h07E);

    // Randomized requests, gaps and transmitter timing.
    for (int r = 0; r < 40; r++) begin
      req_valid = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      set_req(7'($urandom), 8'($urandom), 8'($urandom));
      req_valid = 1'b1;
      step();
      for (int i = 0; i < 500 && !m_ready; i++) begin
        req_valid = 1'($urandom_range(0, 1));
        set_req(7'($urandom), 8'($urandom), 8'($urandom));
        step();
      end
      req_valid = 1'b0;
      if (!m_ready) fail("rand_idle");
    end
    chk("rand_queue_drained", exp_q.size(), 0);
    chk_on = 1'b0;

    // Byte 0 never raises busy: abort from WAIT_ACCEPT after TO cycles there.
    xm_clear();
    never_byte = 0;
    d0 = n_done; n_err = 0; err_cyc = -1;
    set_req(7'h11, 8'h22, 8'h33);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    c1 = cyc;
    chk("to0_first_send", tx_send_en, 1);
    for (int i = 0; i < TO + 50 && n_err == 0; i++) step();
    chk("to0_err_cyc", err_cyc, c1 + 1 + TO);
    chk("to0_err_byte", err_byte, 0);
    chk("to0_ready", req_ready, 1);
    chk("to0_no_done", n_done - d0, 0);
    step();
    chk("to0_error_one_cycle", error, 0);

    // Busy stuck high on byte 1: abort from WAIT_DONE.
    xm_clear();
    stuck_byte = 1;
    d0 = n_done; n_err = 0; err_cyc = -1; r1 = -1000;
    set_req(7'h68, 8'h44, 8'h55);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sends == 2 && tx_busy) begin
        r1 = cyc;
        break;
      end
      step();
    end
    if (r1 < 0) fail("stuck_byte1_rise");
    for (int i = 0; i < TO + 50 && n_err == 0; i++) step();
    chk("stuck_err_cyc", err_cyc, r1 + 1 + TO);
    chk("stuck_err_byte", err_byte, 1);
    chk("stuck_ready", req_ready, 1);
    chk("stuck_no_done", n_done - d0, 0);
    xm_clear();
    repeat (3) step();
    chk("stuck_err_byte_held", err_byte, 1);

    // Reset while in WAIT_DONE of byte 1.
    xm_clear();
    bsy_fixed = 10;
    d0 = n_done;
    set_req(7'h68, 8'h66, 8'h77);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 200 && !(sends == 2 && tx_busy); i++) step();
    step();
    chk("rstmid_pre_busy", busy, 1);
    rst = 1'b1;
    step();
    chk("rstmid_tx_data", tx_data, 0);
    chk("rstmid_tx_is_addr", tx_is_addr, 0);
    chk("rstmid_tx_send_en", tx_send_en, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_error", error, 0);
    chk("rstmid_err_byte", err_byte, 0);
    chk("rstmid_req_ready", req_ready, 0);
    rst = 1'b0;
    step();
    chk("rstmid_ready_after", req_ready, 1);
    repeat (30) step();
    chk("rstmid_no_done", n_done - d0, 0);
    chk("rstmid_no_more_bytes", sends, 2);
    bsy_fixed = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
